// File: rtl/int_priority_encoder_8_to_3.sv
// Interrupt priority encoder for the LC-3 core: edge-detects eight device lines into
// pending latches and presents the highest unmasked level above cur_pl until acknowledged.
module int_priority_encoder_8_to_3 #(
  parameter logic [7:0] VECTOR_BASE = 8'h80
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] irq,
  input  logic [7:0] irq_mask,
  input  logic [2:0] cur_pl,
  input  logic       int_ack,
  output logic       int_req,
  output logic [2:0] int_pl,
  output logic [7:0] int_vec,
  output logic [7:0] pending
);

  localparam int unsigned N_LINES = 8;
  localparam int unsigned PL_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N_LINES-1:0]  r_irq_q;
  logic [N_LINES-1:0]  r_pending;
  logic                r_int_req;
  logic [PL_W-1:0]     r_int_pl;
  logic [7:0]          r_int_vec;

  logic [N_LINES-1:0]  w_rise;
  logic [N_LINES-1:0]  w_cand;
  logic [N_LINES-1:0]  w_clr;
  logic [PL_W-1:0]     w_h;
  logic                w_eligible;
  logic                w_load;
  logic                w_accept;

  assign w_rise = irq & ~r_irq_q;
  assign w_cand = r_pending & irq_mask;

  // Highest set bit of the masked pending set; ascending scan lets the top bit win.
  always_comb begin
    w_h = '0;
    for (int i = 0; i < int'(N_LINES); i++) begin
      if (w_cand[i]) w_h = PL_W'(i);
    end
  end

  assign w_eligible = (|w_cand) && (w_h > cur_pl);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_eligible) w_state_nxt = REQ;
      REQ:     if (int_ack)    w_state_nxt = HOLD;
      HOLD:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Load strobes derived from state; ack outside REQ has no effect.
  always_comb begin
    w_load   = 1'b0;
    w_accept = 1'b0;
    w_clr    = '0;
    case (r_state)
      IDLE:    w_load = w_eligible;
      REQ: begin
        w_accept = int_ack;
        if (int_ack) w_clr = N_LINES'(1) << r_int_pl;
      end
      default: ;
    endcase
  end

  // A same-cycle rise overrides the clear, so a fresh event on the acked line survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_q   <= '0;
      r_pending <= '0;
      r_int_req <= 1'b0;
      r_int_pl  <= '0;
      r_int_vec <= '0;
    end else begin
      r_irq_q   <= irq;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (w_load) begin
        r_int_req <= 1'b1;
        r_int_pl  <= w_h;
        r_int_vec <= 8'(VECTOR_BASE + 8'(w_h));
      end else if (w_accept) begin
        r_int_req <= 1'b0;
      end
    end
  end

  assign int_req = r_int_req;
  assign int_pl  = r_int_pl;
  assign int_vec = r_int_vec;
  assign pending = r_pending;

endmodule
